// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: three 2-deep request FIFOs drained round-robin onto the regfile write and R0 ports.
// Latency: accept edge -> grant next cycle -> registered write strobe the cycle after (2 cycles minimum).
// Backpressure: *_ready from the registered FIFO count only; low while full or in reset.

// Two-entry FIFO with a registered occupancy count; slot0 is always the head.
// Latency: an entry pushed on an edge is visible at the head in the following cycle.
// Backpressure: push_rdy low at count 2 (even if a pop happens that cycle) and during reset.
module regfile_wb_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         head_vld,
    output logic [W-1:0] head_dat
);
    logic [1:0]   count;
    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic         acc;

    assign push_rdy = (count < 2'd2) && !reset;
    assign acc      = push_vld && push_rdy;
    assign head_vld = (count != 2'd0);
    assign head_dat = slot0;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({acc, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= push_dat;
                    else               slot1 <= push_dat;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps the count; a push at count 2 cannot occur.
                    if (count == 2'd1) begin
                        slot0 <= push_dat;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// Round-robin write-back arbiter in front of the 16x16 register file.
// Latency: 2 cycles accept-to-strobe; one write per cycle sustained.
// Backpressure: each producer sees its own FIFO ready; strobes are never stalled.
module regfile_wb_arbiter #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic          md_valid,
    output logic          md_ready,
    input  logic [AW-1:0] md_addr,
    input  logic [DW-1:0] md_lo,
    input  logic [DW-1:0] md_hi,
    output logic [AW-1:0] wadd,
    output logic [DW-1:0] wdata,
    output logic          regwrite,
    output logic [DW-1:0] wr0,
    output logic          r0write,
    output logic [2:0]    pending,
    output logic          idle
);
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
    } md_t;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_MD  = 2'd2;

    wr_t        alu_head;
    wr_t        mem_head;
    md_t        md_head;
    logic       alu_vld;
    logic       mem_vld;
    logic       md_vld;
    logic       alu_pop;
    logic       mem_pop;
    logic       md_pop;
    logic [3:0] nonempty;
    logic [1:0] rr;
    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;
    logic [1:0] gnt_idx;
    logic       gnt_vld;

    function automatic logic [1:0] inc3(input logic [1:0] s);
        return (s == SRC_MD) ? SRC_ALU : s + 2'd1;
    endfunction

    regfile_wb_fifo2 #(.W(AW + DW)) u_alu_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (alu_valid),
        .push_rdy (alu_ready),
        .push_dat ({alu_addr, alu_data}),
        .pop      (alu_pop),
        .head_vld (alu_vld),
        .head_dat (alu_head)
    );

    regfile_wb_fifo2 #(.W(AW + DW)) u_mem_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (mem_valid),
        .push_rdy (mem_ready),
        .push_dat ({mem_addr, mem_data}),
        .pop      (mem_pop),
        .head_vld (mem_vld),
        .head_dat (mem_head)
    );

    regfile_wb_fifo2 #(.W(AW + 2 * DW)) u_md_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (md_valid),
        .push_rdy (md_ready),
        .push_dat ({md_addr, md_lo, md_hi}),
        .pop      (md_pop),
        .head_vld (md_vld),
        .head_dat (md_head)
    );

    assign nonempty = {1'b0, md_vld, mem_vld, alu_vld};
    assign cand0    = rr;
    assign cand1    = inc3(cand0);
    assign cand2    = inc3(cand1);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr;
        if (nonempty[cand0]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand0;
        end else if (nonempty[cand1]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand1;
        end else if (nonempty[cand2]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand2;
        end
    end

    assign alu_pop = gnt_vld && (gnt_idx == SRC_ALU);
    assign mem_pop = gnt_vld && (gnt_idx == SRC_MEM);
    assign md_pop  = gnt_vld && (gnt_idx == SRC_MD);

    always_ff @(posedge clk) begin
        if (reset)        rr <= SRC_ALU;
        else if (gnt_vld) rr <= inc3(gnt_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite <= 1'b0;
            r0write  <= 1'b0;
            wadd     <= '0;
            wdata    <= '0;
            wr0      <= '0;
        end else begin
            regwrite <= 1'b0;
            r0write  <= 1'b0;
            if (gnt_vld) begin
                case (gnt_idx)
                    SRC_ALU: begin
                        regwrite <= 1'b1;
                        wadd     <= alu_head.addr;
                        wdata    <= alu_head.data;
                    end
                    SRC_MEM: begin
                        regwrite <= 1'b1;
                        wadd     <= mem_head.addr;
                        wdata    <= mem_head.data;
                    end
                    default: begin
                        r0write <= 1'b1;
                        wr0     <= md_head.hi;
                        // An md result aimed at R0 keeps only hi, so R0 is not written twice.
                        if (md_head.addr != '0) begin
                            regwrite <= 1'b1;
                            wadd     <= md_head.addr;
                            wdata    <= md_head.lo;
                        end
                    end
                endcase
            end
        end
    end

    assign pending = {md_vld, mem_vld, alu_vld};
    assign idle    = (pending == 3'b000) && !regwrite && !r0write;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed stimulus for regfile_wb_arbiter; expected writes are queued and matched by a negedge monitor.
module tb_regfile_wb_arbiter;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, mem_valid, md_valid;
    logic          alu_ready, mem_ready, md_ready;
    logic [AW-1:0] alu_addr, mem_addr, md_addr;
    logic [DW-1:0] alu_data, mem_data, md_lo, md_hi;
    logic [AW-1:0] wadd;
    logic [DW-1:0] wdata, wr0;
    logic          regwrite, r0write, idle;
    logic [2:0]    pending;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .md_valid  (md_valid),
        .md_ready  (md_ready),
        .md_addr   (md_addr),
        .md_lo     (md_lo),
        .md_hi     (md_hi),
        .wadd      (wadd),
        .wdata     (wdata),
        .regwrite  (regwrite),
        .wr0       (wr0),
        .r0write   (r0write),
        .pending   (pending),
        .idle      (idle)
    );

    typedef struct {
        logic        rw;
        logic        r0w;
        logic [3:0]  wadd;
        logic [15:0] wdata;
        logic [15:0] wr0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_wr(input logic rw, input logic r0w, input logic [3:0] a,
                             input logic [15:0] d, input logic [15:0] h);
        exp_t e;
        e.rw = rw; e.r0w = r0w; e.wadd = a; e.wdata = d; e.wr0 = h;
        sb.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (regwrite === 1'b1 || r0write === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL wb_write unexpected: regwrite=%b r0write=%b wadd=%0h wdata=%0h wr0=%0h",
                         regwrite, r0write, wadd, wdata, wr0);
            end else begin
                mon_e = sb.pop_front();
                if (regwrite === mon_e.rw && r0write === mon_e.r0w &&
                    (!mon_e.rw || (wadd === mon_e.wadd && wdata === mon_e.wdata)) &&
                    (!mon_e.r0w || wr0 === mon_e.wr0))
                    passed++;
                else
                    $display("FAIL wb_write: got rw=%b r0w=%b wadd=%0h wdata=%0h wr0=%0h expected rw=%b r0w=%b wadd=%0h wdata=%0h wr0=%0h",
                             regwrite, r0write, wadd, wdata, wr0,
                             mon_e.rw, mon_e.r0w, mon_e.wadd, mon_e.wdata, mon_e.wr0);
            end
        end
    end

    task automatic drive_alu(input int n);
        int sent = 0;
        int budget = 0;
        while (sent < n && budget < 60) begin
            alu_valid = 1'b1;
            alu_addr  = 4'hA;
            alu_data  = 16'hA000 + 16'(sent);
            @(negedge clk);
            if (alu_ready) sent++;
            @(posedge clk);
            #1;
            budget++;
        end
        alu_valid = 1'b0;
        chk("alu_drive_done", sent, n);
    endtask

    task automatic drive_mem(input int n);
        int   sent = 0;
        int   budget = 0;
        logic saw_stall = 1'b0;
        while (sent < n && budget < 60) begin
            mem_valid = 1'b1;
            mem_addr  = 4'hB;
            mem_data  = 16'hB000 + 16'(sent);
            @(negedge clk);
            if (mem_ready) sent++;
            else if (sent == 2) saw_stall = 1'b1;
            @(posedge clk);
            #1;
            budget++;
        end
        mem_valid = 1'b0;
        chk("mem_drive_done", sent, n);
        chk("mem_ready_drop", saw_stall, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        alu_valid = 1'b1; alu_addr = 4'h1; alu_data = 16'h1111;
        mem_valid = 1'b1; mem_addr = 4'h2; mem_data = 16'h2222;
        md_valid  = 1'b1; md_addr  = 4'h3; md_lo = 16'h3333; md_hi = 16'h4444;
        tick(2);
        chk("rst_alu_ready", alu_ready, 1'b0);
        chk("rst_mem_ready", mem_ready, 1'b0);
        chk("rst_md_ready", md_ready, 1'b0);
        chk("rst_regwrite", regwrite, 1'b0);
        chk("rst_r0write", r0write, 1'b0);
        chk("rst_wadd", wadd, 4'h0);
        chk("rst_wdata", wdata, 16'h0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_pending", pending, 3'b000);
        reset = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0; md_valid = 1'b0;
        #1;
        chk("post_rst_alu_ready", alu_ready, 1'b1);
        chk("post_rst_mem_ready", mem_ready, 1'b1);
        chk("post_rst_md_ready", md_ready, 1'b1);
        tick(4);

        // Single ALU write: strobe exactly two cycles after the accept edge.
        alu_valid = 1'b1; alu_addr = 4'h3; alu_data = 16'hBEEF;
        expect_wr(1'b1, 1'b0, 4'h3, 16'hBEEF, 16'h0);
        tick(1);
        alu_valid = 1'b0;
        chk("alu_grant_cycle_no_strobe", regwrite, 1'b0);
        tick(1);
        chk("alu_write_cycle", regwrite, 1'b1);
        chk("alu_write_no_r0", r0write, 1'b0);
        tick(1);
        chk("alu_strobe_one_cycle", regwrite, 1'b0);
        tick(2);

        // md result to R0: only the R0 port is written.
        md_valid = 1'b1; md_addr = 4'h0; md_lo = 16'h1234; md_hi = 16'hFFFF;
        expect_wr(1'b0, 1'b1, 4'h0, 16'h0, 16'hFFFF);
        tick(1);
        md_valid = 1'b0;
        tick(4);

        // All three at once, round-robin from alu.
        alu_valid = 1'b1; alu_addr = 4'h1; alu_data = 16'h0011;
        mem_valid = 1'b1; mem_addr = 4'h2; mem_data = 16'h0022;
        md_valid  = 1'b1; md_addr  = 4'h5; md_lo = 16'h0055; md_hi = 16'h00AA;
        expect_wr(1'b1, 1'b0, 4'h1, 16'h0011, 16'h0);
        expect_wr(1'b1, 1'b0, 4'h2, 16'h0022, 16'h0);
        expect_wr(1'b1, 1'b1, 4'h5, 16'h0055, 16'h00AA);
        tick(1);
        alu_valid = 1'b0; mem_valid = 1'b0; md_valid = 1'b0;
        tick(1);
        chk("b2b_first", regwrite, 1'b1);
        tick(1);
        chk("b2b_second", regwrite, 1'b1);
        tick(1);
        chk("b2b_third_r0", r0write, 1'b1);
        tick(3);

        // Backpressure: mem interleaves with continuous alu traffic.
        for (int i = 0; i < 3; i++) begin
            expect_wr(1'b1, 1'b0, 4'hA, 16'hA000 + 16'(i), 16'h0);
            expect_wr(1'b1, 1'b0, 4'hB, 16'hB000 + 16'(i), 16'h0);
        end
        expect_wr(1'b1, 1'b0, 4'hA, 16'hA003, 16'h0);
        expect_wr(1'b1, 1'b0, 4'hA, 16'hA004, 16'h0);
        fork
            drive_alu(5);
            drive_mem(3);
        join
        tick(6);

        // Reset mid-stream: rr now points at mem, so only the mem head gets written before reset.
        alu_valid = 1'b1; alu_addr = 4'h1; alu_data = 16'h0101;
        mem_valid = 1'b1; mem_addr = 4'h2; mem_data = 16'h0202;
        md_valid  = 1'b1; md_addr  = 4'h3; md_lo = 16'h0303; md_hi = 16'h0330;
        expect_wr(1'b1, 1'b0, 4'h2, 16'h0202, 16'h0);
        tick(1);
        alu_data = 16'h0111; mem_data = 16'h0222; md_lo = 16'h0333;
        tick(1);
        alu_valid = 1'b0; mem_valid = 1'b0; md_valid = 1'b0;
        chk("fill_pending", pending, 3'b111);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid_rst_regwrite", regwrite, 1'b0);
        chk("mid_rst_r0write", r0write, 1'b0);
        chk("mid_rst_pending", pending, 3'b000);
        chk("mid_rst_idle", idle, 1'b1);
        alu_valid = 1'b1; alu_addr = 4'h7; alu_data = 16'h7777;
        expect_wr(1'b1, 1'b0, 4'h7, 16'h7777, 16'h0);
        tick(1);
        alu_valid = 1'b0;
        chk("post_rst_grant_no_strobe", regwrite, 1'b0);
        tick(1);
        chk("post_rst_write", regwrite, 1'b1);
        chk("post_rst_wadd", wadd, 4'h7);
        tick(4);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
